lap_recorder: RTL and testbench

- Downstream consumer of the stopwatch counter's `unit_tick` count.
- On each lap request while the watch is running, captures the current count and the split since the previous lap, and pushes the pair into a small on-chip FIFO.
- A display/UART stage drains the FIFO through a pop/valid read port.

---
 rtl/lap_pkg.sv | 19 +
 rtl/lap_fifo_mem.sv | 54 +++++
 rtl/lap_recorder.sv | 137 +++++++++++++
 tb/tb_lap_recorder.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lap_pkg.sv
// ---------------------------------------------------------------------------
// lap_pkg
// Shared definitions for the lap recorder slice: default widths/depth and the
// layout of one stored lap entry ({lap_total, split}) as seen on rd_data.
// ---------------------------------------------------------------------------
package lap_pkg;

    localparam int DEF_CNT_W = 8;   // width of the unit count and of each field
    localparam int DEF_DEPTH = 8;   // lap entries held (power of two, >= 2)

    // One lap record; lap_total occupies the upper half of rd_data.
    typedef struct packed {
        logic [DEF_CNT_W-1:0] lap_total;
        logic [DEF_CNT_W-1:0] split;
    } lap_entry_t;

    localparam int ENTRY_W = $bits(lap_entry_t);

endpackage

// File: rtl/lap_fifo_mem.sv
// ---------------------------------------------------------------------------
// lap_fifo_mem
// DEPTH x WIDTH synchronous RAM with one write port and one registered read
// port. A read and a write to the same address in one cycle return the old
// contents.
//
// Ports:
//   clk    - clock, all logic on posedge
//   rst    - synchronous active-low reset (read register only)
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   re     - read enable; rdata updates on the next posedge, holds otherwise
//   raddr  - read address
//   rdata  - registered read data
// ---------------------------------------------------------------------------
module lap_fifo_mem
    import lap_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int WIDTH = ENTRY_W,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the storage array has no reset so it maps onto RAM macros; the
    // FIFO pointers guarantee no location is read before it is written.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; this is also what gives read-before-write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/lap_recorder.sv
// ---------------------------------------------------------------------------
// lap_recorder
// Captures the stopwatch unit count on each lap button edge while running,
// computes the split since the previous accepted lap, and queues the pair
// in a small FIFO that a display/UART stage drains via rd_en/rd_valid.
//
// Ports:
//   clk        - clock, all logic on posedge
//   rst        - synchronous active-low reset
//   running    - counter is counting; lap edges are ignored otherwise
//   unit_count - current registered unit count
//   lap_req    - debounced lap button level; a lap is a rising edge
//   clear      - one-cycle flush of FIFO, split base and overflow
//   rd_en      - pop request
//   rd_data    - {lap_total, split}, valid while rd_valid=1
//   rd_valid   - one-cycle pulse one cycle after an accepted pop
//   level      - entries currently stored
//   full       - level == DEPTH
//   empty      - level == 0
//   overflow   - sticky: a lap was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module lap_recorder
    import lap_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int DEPTH = DEF_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               running,
    input  logic [CNT_W-1:0]   unit_count,
    input  logic               lap_req,
    input  logic               clear,
    input  logic               rd_en,
    output logic [2*CNT_W-1:0] rd_data,
    output logic               rd_valid,
    output logic [PTR_W:0]     level,
    output logic               full,
    output logic               empty,
    output logic               overflow
);

    localparam logic [PTR_W:0] LEVEL_MAX = (PTR_W+1)'(DEPTH);

    logic               lap_req_q;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     level_q;
    logic [CNT_W-1:0]   last_lap;
    logic [CNT_W-1:0]   split;
    logic               overflow_q;
    logic               rd_valid_q;

    logic               lap_evt;
    logic               rd_accept;
    logic               wr_accept;
    logic               wr_drop;

    assign level = level_q;
    assign full  = (level_q == LEVEL_MAX);
    assign empty = (level_q == '0);

    // Wrap-around subtraction gives the correct split across a count rollover.
    assign split = unit_count - last_lap;

    // NOTE: every signal written in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        lap_evt   = 1'b0;
        rd_accept = 1'b0;
        wr_accept = 1'b0;
        wr_drop   = 1'b0;
        if (!clear) begin
            lap_evt   = lap_req & ~lap_req_q & running;
            rd_accept = rd_en & ~empty;
            // A pop at full frees a slot in the same cycle, so the lap fits.
            wr_accept = lap_evt & (~full | rd_accept);
            wr_drop   = lap_evt & ~wr_accept;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            lap_req_q <= 1'b0;
        end else begin
            lap_req_q <= lap_req;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            last_lap   <= '0;
            overflow_q <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_accept;
            if (wr_accept) begin
                wr_ptr   <= wr_ptr + 1'b1;
                last_lap <= unit_count;
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_drop) begin
                overflow_q <= 1'b1;
            end
            case ({wr_accept, rd_accept})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    assign overflow = overflow_q;
    assign rd_valid = rd_valid_q;

    lap_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (2*CNT_W),
        .AW    (PTR_W)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_accept),
        .waddr (wr_ptr),
        .wdata ({unit_count, split}),
        .re    (rd_accept),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_lap_recorder.sv
module tb_lap_recorder;
    import lap_pkg::*;

    localparam int CNT_W = DEF_CNT_W;
    localparam int DEPTH = DEF_DEPTH;
    localparam int PTR_W = $clog2(DEPTH);

    logic               clk = 1'b0;
    logic               rst;
    logic               running;
    logic [CNT_W-1:0]   unit_count;
    logic               lap_req;
    logic               clear;
    logic               rd_en;
    logic [2*CNT_W-1:0] rd_data;
    logic               rd_valid;
    logic [PTR_W:0]     level;
    logic               full;
    logic               empty;
    logic               overflow;

    int n_cmp = 0;
    int n_bad = 0;
    lap_entry_t exp_q[$];

    lap_recorder #(.CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .running    (running),
        .unit_count (unit_count),
        .lap_req    (lap_req),
        .clear      (clear),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .level      (level),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Monitor: every rd_valid pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst === 1'b1 && rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_rd_valid: got rd_data 0x%0h with no pop expected at %0t", rd_data, $time);
            end else begin
                lap_entry_t e;
                e = exp_q.pop_front();
                check("rd_data", 32'(rd_data), 32'(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lap(input int cnt);
        unit_count = CNT_W'(cnt);
        lap_req    = 1'b1;
        tick();
        lap_req    = 1'b0;
        tick();
    endtask

    task automatic pop(input int tot, input int spl);
        lap_entry_t e;
        e.lap_total = CNT_W'(tot);
        e.split     = CNT_W'(spl);
        exp_q.push_back(e);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic check_flags(input string tag, input int lvl, input bit f, input bit e, input bit ovf);
        check({tag, "_level"}, 32'(level), 32'(lvl));
        check({tag, "_full"}, 32'(full), 32'(f));
        check({tag, "_empty"}, 32'(empty), 32'(e));
        check({tag, "_overflow"}, 32'(overflow), 32'(ovf));
    endtask

    initial begin
        rst        = 1'b0;
        running    = 1'b0;
        unit_count = '0;
        lap_req    = 1'b0;
        clear      = 1'b0;
        rd_en      = 1'b0;
        tick();
        tick();
        check_flags("reset", 0, 0, 1, 0);
        check("reset_rd_valid", 32'(rd_valid), 0);
        check("reset_rd_data", 32'(rd_data), 0);
        rst     = 1'b1;
        running = 1'b1;
        tick();

        // Basic laps
        lap(5);
        lap(12);
        lap(20);
        check_flags("basic", 3, 0, 0, 0);
        pop(5, 5);
        pop(12, 7);
        pop(20, 8);
        check_flags("basic_drained", 0, 0, 1, 0);

        // Overflow: last_lap = 20, laps at 30,32,...,46
        for (int i = 0; i < 8; i++) lap(30 + 2 * i);
        check_flags("fill8", 8, 1, 0, 0);
        lap(46);
        check_flags("lap9", 8, 1, 0, 1);
        pop(30, 10);
        for (int i = 1; i < 8; i++) pop(30 + 2 * i, 2);
        tick();
        check_flags("ovf_drained", 0, 0, 1, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_flags("ovf_cleared", 0, 0, 1, 0);

        // Split wrap, held button, running=0
        lap(250);
        lap(3);
        unit_count = 8'd60;
        lap_req    = 1'b1;
        repeat (10) tick();
        lap_req    = 1'b0;
        tick();
        check("held_level", 32'(level), 3);
        running = 1'b0;
        lap(70);
        check("stopped_level", 32'(level), 3);
        running = 1'b1;
        pop(250, 250);
        pop(3, 9);
        pop(60, 57);

        // Simultaneous at full: last_lap = 60
        for (int i = 1; i <= 8; i++) lap(60 + i);
        check("sim_full_level", 32'(level), 8);
        unit_count = 8'd69;
        lap_req    = 1'b1;
        exp_q.push_back('{lap_total: 8'd61, split: 8'd1});
        rd_en      = 1'b1;
        tick();
        lap_req    = 1'b0;
        rd_en      = 1'b0;
        tick();
        check_flags("sim_full", 8, 1, 0, 0);
        for (int i = 2; i <= 9; i++) pop(60 + i, 1);
        tick();
        check("sim_drained_empty", 32'(empty), 1);

        // Simultaneous at empty: last_lap = 69
        unit_count = 8'd75;
        lap_req    = 1'b1;
        rd_en      = 1'b1;
        tick();
        check("sim_empty_rd_valid", 32'(rd_valid), 0);
        lap_req    = 1'b0;
        rd_en      = 1'b0;
        tick();
        check("sim_empty_level", 32'(level), 1);
        pop(75, 6);

        // Clear priority: last_lap = 75
        lap(80);
        lap(81);
        lap(82);
        check("clr_pre_level", 32'(level), 3);
        unit_count = 8'd85;
        clear      = 1'b1;
        lap_req    = 1'b1;
        rd_en      = 1'b1;
        tick();
        check("clr_rd_valid", 32'(rd_valid), 0);
        check_flags("clr", 0, 0, 1, 0);
        clear   = 1'b0;
        lap_req = 1'b0;
        rd_en   = 1'b0;
        tick();
        lap(40);
        pop(40, 40);
        tick();

        // Synchronous reset: last_lap = 40
        lap(50);
        check("pre_rst_level", 32'(level), 1);
        #2;
        rst = 1'b0;
        #1;
        check("rst_no_edge_level", 32'(level), 1);
        check("rst_no_edge_empty", 32'(empty), 0);
        tick();
        check_flags("sync_rst", 0, 0, 1, 0);
        check("sync_rst_rd_data", 32'(rd_data), 0);
        check("sync_rst_rd_valid", 32'(rd_valid), 0);
        rst   = 1'b1;
        tick();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("pop_after_rst_rd_valid", 32'(rd_valid), 0);
        tick();

        // Bounded wait for any outstanding expected pops.
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL pending_pops: got %0d outstanding expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
